// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: feeds a byte stream one byte at a time to an external 4-bit
// window matcher and accumulates the hit count and the first-hit location per frame.
//
// state  | meaning
// S_IDLE | waiting for start; previous results held
// S_LOAD | in_ready high, waiting for the next text byte
// S_EVAL | matcher hit vector sampled, counters updated
// S_DONE | one-cycle done pulse, then back to idle
module pattern_scan_ctrl #(
  parameter int CNT_W = 16,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       pattern,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       m_text,
  output logic [3:0]       m_pat,
  input  logic [4:0]       m_pos,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [IDX_W-1:0] byte_cnt,
  output logic             first_found,
  output logic [IDX_W-1:0] first_byte,
  output logic [2:0]       first_pos
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           w_start_acc;
  logic           w_byte_acc;
  logic           w_eval_upd;
  logic           r_last;
  logic [2:0]     w_pop;
  logic [2:0]     w_hi;
  logic [CNT_W:0] w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // abort is checked ahead of byte acceptance and in_last so a frame can always be dropped
  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_byte_acc  = 1'b0;
    w_eval_upd  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_next      = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (in_valid) begin
          w_byte_acc = 1'b1;
          w_next     = S_EVAL;
        end
      end
      S_EVAL: begin
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_eval_upd = 1'b1;
          w_next     = r_last ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign in_ready = (r_state == S_LOAD);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

  always_comb begin
    w_pop = '0;
    w_hi  = '0;
    for (int k = 0; k < 5; k++) begin
      if (m_pos[k]) begin
        w_pop = w_pop + 3'd1;
        w_hi  = 3'(k);
      end
    end
  end

  // one extra bit catches the carry so the count can clamp at all-ones
  assign w_sum = {1'b0, match_cnt} + (CNT_W+1)'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_text      <= '0;
      m_pat       <= '0;
      r_last      <= 1'b0;
      match_cnt   <= '0;
      byte_cnt    <= '0;
      first_found <= 1'b0;
      first_byte  <= '0;
      first_pos   <= '0;
    end else begin
      if (w_start_acc) begin
        m_pat       <= pattern;
        match_cnt   <= '0;
        byte_cnt    <= '0;
        first_found <= 1'b0;
        first_byte  <= '0;
        first_pos   <= '0;
      end
      if (w_byte_acc) begin
        m_text <= in_data;
        r_last <= in_last;
      end
      if (w_eval_upd) begin
        match_cnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        if (byte_cnt != {IDX_W{1'b1}}) byte_cnt <= byte_cnt + IDX_W'(1);
        if (!first_found && (m_pos != 5'd0)) begin
          first_found <= 1'b1;
          first_byte  <= byte_cnt;
          first_pos   <= w_hi;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: a default-width instance and a 3-bit-counter instance
// share stimulus; expected results come from a per-byte window-count model.
module tb_pattern_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] pattern;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;

  logic        in_ready_a, busy_a, done_a, ff_a;
  logic [7:0]  m_text_a, bc_a, fb_a;
  logic [3:0]  m_pat_a;
  logic [4:0]  m_pos_a;
  logic [15:0] mc_a;
  logic [2:0]  fp_a;

  logic        in_ready_b, busy_b, done_b, ff_b;
  logic [7:0]  m_text_b, bc_b, fb_b;
  logic [3:0]  m_pat_b;
  logic [4:0]  m_pos_b;
  logic [2:0]  mc_b;
  logic [2:0]  fp_b;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  int exp16, exp3, exp_bytes, exp_ff, exp_fb, exp_fp;
  logic [7:0] frame_q [16];

  pattern_scan_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready_a),
    .m_text(m_text_a), .m_pat(m_pat_a), .m_pos(m_pos_a), .busy(busy_a), .done(done_a),
    .match_cnt(mc_a), .byte_cnt(bc_a), .first_found(ff_a), .first_byte(fb_a),
    .first_pos(fp_a)
  );

  pattern_scan_ctrl #(.CNT_W(3), .IDX_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready_b),
    .m_text(m_text_b), .m_pat(m_pat_b), .m_pos(m_pos_b), .busy(busy_b), .done(done_b),
    .match_cnt(mc_b), .byte_cnt(bc_b), .first_found(ff_b), .first_byte(fb_b),
    .first_pos(fp_b)
  );

  // external matcher: bit k flags text window [k+3:k] equal to the pattern
  always_comb begin
    m_pos_a = '0;
    m_pos_b = '0;
    for (int k = 0; k < 5; k++) begin
      m_pos_a[k] = (m_text_a[k +: 4] == m_pat_a);
      m_pos_b[k] = (m_text_b[k +: 4] == m_pat_b);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done_a) done_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int n_hits(input int b, input int p);
    int n = 0;
    for (int k = 0; k < 5; k++) if (((b / (1 << k)) % 16) == p) n++;
    return n;
  endfunction

  function automatic int top_hit(input int b, input int p);
    int t = 0;
    for (int k = 0; k < 5; k++) if (((b / (1 << k)) % 16) == p) t = k;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp16 = 0; exp3 = 0; exp_bytes = 0; exp_ff = 0; exp_fb = 0; exp_fp = 0;
  endtask

  task automatic model_byte(input int b, input int p);
    int h;
    h = n_hits(b, p);
    if (exp_ff == 0 && h > 0) begin
      exp_ff = 1;
      exp_fb = exp_bytes;
      exp_fp = top_hit(b, p);
    end
    exp16 = (exp16 + h > 65535) ? 65535 : exp16 + h;
    exp3  = (exp3 + h > 7) ? 7 : exp3 + h;
    exp_bytes = (exp_bytes + 1 > 255) ? 255 : exp_bytes + 1;
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_mc16"}, 32'(mc_a), 32'(exp16));
    chk({tag, "_mc3"},  32'(mc_b), 32'(exp3));
    chk({tag, "_bc"},   32'(bc_a), 32'(exp_bytes));
    chk({tag, "_ff"},   32'(ff_a), 32'(exp_ff));
    chk({tag, "_fb"},   32'(fb_a), 32'(exp_fb));
    chk({tag, "_fp"},   32'(fp_a), 32'(exp_fp));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(in_ready_a), 32'd0);
    chk({tag, "_busy"},  32'(busy_a), 32'd0);
    chk({tag, "_done"},  32'(done_a), 32'd0);
    chk({tag, "_text"},  32'(m_text_a), 32'd0);
    chk({tag, "_pat"},   32'(m_pat_a), 32'd0);
    chk({tag, "_mc16"},  32'(mc_a), 32'd0);
    chk({tag, "_mc3"},   32'(mc_b), 32'd0);
    chk({tag, "_bc"},    32'(bc_a), 32'd0);
    chk({tag, "_ff"},    32'(ff_a), 32'd0);
    chk({tag, "_fb"},    32'(fb_a), 32'd0);
    chk({tag, "_fp"},    32'(fp_a), 32'd0);
  endtask

  // Runs one frame from IDLE (entered and left at a falling edge). ab_idx < 0: no abort.
  task automatic run_frame(input logic [3:0] p, input int n, input int ab_idx,
                           input bit ab_eval, input int min_gap, input int max_gap);
    bit aborted;
    int d0, t;
    aborted = 1'b0;
    d0 = done_seen;
    model_clear();
    start = 1'b1; pattern = p;
    @(negedge clk);
    start = 1'b0; pattern = 4'($urandom);
    chk("start_busy", 32'(busy_a), 32'd1);
    chk("start_ready", 32'(in_ready_a), 32'd1);
    chk_results("start_clr");
    for (int i = 0; i < n && !aborted; i++) begin
      t = $urandom_range(min_gap, max_gap);
      repeat (t) begin
        start = 1'($urandom_range(0, 1)); pattern = 4'($urandom);
        @(negedge clk);
        chk("stall_ready", 32'(in_ready_a), 32'd1);
        chk("stall_bc", 32'(bc_a), 32'(exp_bytes));
        chk("stall_mc", 32'(mc_a), 32'(exp16));
      end
      start = 1'b0;
      if (ab_idx == i && !ab_eval) begin
        abort = 1'b1; in_valid = 1'b1; in_data = frame_q[i]; in_last = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("abl_busy", 32'(busy_a), 32'd0);
        chk("abl_ready", 32'(in_ready_a), 32'd0);
        aborted = 1'b1;
      end else begin
        in_valid = 1'b1; in_data = frame_q[i]; in_last = (i == n - 1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
        chk("eval_text", 32'(m_text_a), 32'(frame_q[i]));
        chk("eval_pat", 32'(m_pat_a), 32'(p));
        chk("eval_ready", 32'(in_ready_a), 32'd0);
        if (ab_idx == i && ab_eval) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk("abe_busy", 32'(busy_a), 32'd0);
          aborted = 1'b1;
        end else begin
          model_byte(frame_q[i], p);
          @(negedge clk);
          if (i == n - 1) chk("done_pulse", 32'(done_a), 32'd1);
          else            chk("next_ready", 32'(in_ready_a), 32'd1);
        end
      end
    end
    if (!aborted) begin
      @(negedge clk);
      chk("post_done", 32'(done_a), 32'd0);
      chk("post_busy", 32'(busy_a), 32'd0);
    end
    chk_results("end");
    chk("done_count", 32'(done_seen - d0), aborted ? 32'd0 : 32'd1);
    repeat (2) @(negedge clk);
    chk_results("held");
  endtask

  initial begin
    int n, ab_idx;
    logic [3:0] p;
    bit ab_eval;
    rst_n = 1'b0; start = 1'b0; pattern = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    #3;
    chk_zero("reset");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_abort_busy", 32'(busy_a), 32'd0);
    abort = 1'b0;

    frame_q[0] = 8'b1110_0011;
    run_frame(4'b1110, 1, -1, 1'b0, 0, 0);
    chk("s1_mc", 32'(mc_a), 32'd1);
    chk("s1_fp", 32'(fp_a), 32'd4);

    frame_q[0] = 8'b1011_1011; frame_q[1] = 8'b1110_1011;
    run_frame(4'b1010, 2, -1, 1'b0, 0, 1);
    chk("s2_mc", 32'(mc_a), 32'd1);
    chk("s2_fb", 32'(fb_a), 32'd1);
    chk("s2_fp", 32'(fp_a), 32'd2);

    frame_q[0] = 8'h00;
    run_frame(4'b0000, 1, -1, 1'b0, 0, 0);
    chk("s3_mc", 32'(mc_a), 32'd5);
    frame_q[0] = 8'h00; frame_q[1] = 8'h00;
    run_frame(4'b0000, 2, -1, 1'b0, 0, 0);
    chk("s3_sat", 32'(mc_b), 32'd7);
    chk("s3_nosat", 32'(mc_a), 32'd10);

    frame_q[0] = 8'h66; frame_q[1] = 8'h3C;
    run_frame(4'b0110, 2, -1, 1'b0, 5, 5);

    frame_q[0] = 8'h5A; frame_q[1] = 8'hA5; frame_q[2] = 8'hFF;
    run_frame(4'b0101, 3, 1, 1'b0, 0, 1);
    chk("s5_bc", 32'(bc_a), 32'd1);
    run_frame(4'b1010, 3, 1, 1'b1, 0, 1);

    // reset asserted in the middle of an EVAL cycle
    model_clear();
    n = done_seen;
    start = 1'b1; pattern = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy_a), 32'd0);
    end
    chk("rst_no_done", 32'(done_seen - n), 32'd0);

    repeat (24) begin
      p = 4'($urandom);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        frame_q[i] = ($urandom_range(0, 2) == 0) ? {p, p} : 8'($urandom);
      ab_idx = -1;
      ab_eval = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        ab_idx = $urandom_range(0, n - 1);
        ab_eval = 1'($urandom_range(0, 1));
      end
      run_frame(p, n, ab_idx, ab_eval, 0, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the match counter.
REQ-002 SHALL have parameter IDX_W, default 8: width of the byte index and byte counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous active-low reset).
REQ-004 SHALL have port start input 1: frame start request, sampled in IDLE.
REQ-005 SHALL have port pattern input 4: search pattern, latched when start is accepted.
REQ-006 SHALL have port abort input 1: synchronous frame abort.
REQ-007 SHALL have ports in_valid input 1, in_data input 8, in_last input 1, in_ready output 1: text byte stream.
REQ-008 SHALL have ports m_text output 8 and m_pat output 4: registered drive to the external 8-bit/4-bit pattern matcher.
REQ-009 SHALL have port m_pos input 5: matcher hit vector; bit k set means m_text[k+3:k]==m_pat, k=0..4.
REQ-010 SHALL have ports busy output 1 and done output 1: busy is high outside IDLE; done is a one-cycle completion pulse.
REQ-011 SHALL have result ports: match_cnt output CNT_W; byte_cnt output IDX_W; first_found output 1; first_byte output IDX_W; first_pos output 3.

Function
REQ-012 SHALL implement the FSM IDLE, LOAD, EVAL, DONE.
REQ-013 IDLE: start=1 SHALL latch pattern into m_pat, clear all result outputs, and go to LOAD; otherwise stay in IDLE.
REQ-014 LOAD: in_ready SHALL be 1 only in LOAD; a byte is accepted on in_valid&in_ready, which latches in_data into m_text and in_last internally, then goes to EVAL.
REQ-015 LOAD with in_valid=0 SHALL stall with no result change.
REQ-016 EVAL: m_pos SHALL be sampled at the end of the EVAL cycle (matcher is combinational from registered m_text/m_pat).
REQ-017 EVAL: match_cnt SHALL add popcount(m_pos), saturating at 2^CNT_W-1.
REQ-018 EVAL: byte_cnt SHALL increment, saturating at 2^IDX_W-1.
REQ-019 EVAL, first hit of frame: if first_found=0 and m_pos!=0, SHALL set first_found=1, first_byte=byte_cnt (pre-increment, 0-based), first_pos=highest set bit index of m_pos.
REQ-020 EVAL next state: SHALL go to DONE if latched in_last=1, else to LOAD.
REQ-021 Throughput SHALL be one byte per 2 cycles minimum; windows are byte-aligned, with no matches spanning byte boundaries.
REQ-022 DONE: done SHALL be 1 for exactly one cycle, then go to IDLE; results are held until the next accepted start.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 abort=1 in LOAD or EVAL SHALL go to IDLE next cycle with no done and no EVAL update that cycle; results are held as partial.
REQ-025 abort SHALL take priority over byte acceptance and over in_last.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 m_pat SHALL be stable from start accept to return to IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and zero every output (in_ready, busy, done, m_text, m_pat, match_cnt, byte_cnt, first_found, first_byte, first_pos), regardless of clk.
REQ-029 Reset mid-frame SHALL discard the frame, with no done pulse after release.
REQ-030 After rst_n rises, the first accepted start SHALL take effect on the first rising clk edge.

Verification (bench models matcher: m_pos[k] = (m_text[k+3:k]==m_pat))
REQ-031 Scenario: pattern=1110, single byte 11100011 with last -> match_cnt=1, byte_cnt=1, first_found=1, first_byte=0, first_pos=4, one done pulse.
REQ-032 Scenario: pattern=1010, bytes 10111011 then 11101011 (last) -> match_cnt=1, byte_cnt=2, first_byte=1, first_pos=2.
REQ-033 Scenario: pattern=0000, byte 00000000 (last) -> match_cnt=5, first_pos=4; with CNT_W=3 and two such bytes -> match_cnt saturates at 7.
REQ-034 Scenario: in_valid low for 5 cycles in LOAD -> in_ready stays 1, no counter change; start pulsed while busy -> ignored, m_pat unchanged.
REQ-035 Scenario: abort during LOAD after 1 byte -> IDLE next cycle, busy=0, no done, byte_cnt=1 held.
REQ-036 Scenario: rst_n low during EVAL -> all outputs 0 asynchronously, no done after release.
